// File: rtl/rom_sequencer_if.sv
// ---------------------------------------------------------------------------
// rom_sequencer_if
//   Bundles the control, ROM and sample-output signals of rom_sequencer.
//
//   Signals
//     run         playback enable (1 = play, 0 = return to IDLE)
//     mode        0 = hold active channel, 1 = auto round-robin
//     ch_en[3:0]  per-channel enable, bit i enables channel i
//     rom_data0..3  synchronous ROM read data, valid one cycle after rom_addr
//     rom_addr    shared ROM address
//     active_ch   channel currently addressed
//     data_out    last sample of the played channel
//     data_valid  one-cycle strobe per new data_out sample
//     ch_done     one-cycle pulse on the last address of a channel
//
//   Modports
//     master  controller / ROM side (drives run, mode, ch_en, rom_data*)
//     slave   sequencer side (drives rom_addr, active_ch, data_out, ...)
// ---------------------------------------------------------------------------
interface rom_sequencer_if;
  logic       run;
  logic       mode;
  logic [3:0] ch_en;
  logic [7:0] rom_data0;
  logic [7:0] rom_data1;
  logic [7:0] rom_data2;
  logic [7:0] rom_data3;
  logic [7:0] rom_addr;
  logic [1:0] active_ch;
  logic [7:0] data_out;
  logic       data_valid;
  logic       ch_done;

  modport master (
    output run, mode, ch_en, rom_data0, rom_data1, rom_data2, rom_data3,
    input  rom_addr, active_ch, data_out, data_valid, ch_done
  );

  modport slave (
    input  run, mode, ch_en, rom_data0, rom_data1, rom_data2, rom_data3,
    output rom_addr, active_ch, data_out, data_valid, ch_done
  );
endinterface

// File: rtl/rom_sequencer.sv
// ---------------------------------------------------------------------------
// rom_sequencer
//   Plays back four sample ROMs of lengths LEN0..LEN3 through one shared
//   address bus. In PLAY the address advances one step at a time; at the
//   last address of the active channel it wraps to 0, pulses ch_done and
//   picks the next channel from a fresh snapshot of ch_en (round-robin when
//   mode=1, hold when mode=0). Samples come back two cycles after their
//   address step with a one-cycle data_valid strobe.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    rom_sequencer_if.slave (run, mode, ch_en, rom_data0..3 in;
//            rom_addr, active_ch, data_out, data_valid, ch_done out)
//
//   Parameters
//     LEN0..LEN3  samples per channel ROM (1..256)
//     DIV         pacer divide ratio (2..16), used only with the pacer
//
//   Configuration
//     ROM_SEQUENCER_PACER_EN  when defined, a 4-bit pacer restricts address
//                             steps to one every DIV cycles; otherwise the
//                             address steps every PLAY cycle.
// ---------------------------------------------------------------------------
module rom_sequencer #(
  parameter int unsigned LEN0 = 132,
  parameter int unsigned LEN1 = 121,
  parameter int unsigned LEN2 = 88,
  parameter int unsigned LEN3 = 55,
  parameter int unsigned DIV  = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  rom_sequencer_if.slave bus
);

  // Elaboration-time parameter sanity checks.
  if (DIV < 2 || DIV > 16) begin : g_bad_div
    $error("rom_sequencer: DIV must lie in 2..16");
  end
  if (LEN0 < 1 || LEN0 > 256 || LEN1 < 1 || LEN1 > 256 ||
      LEN2 < 1 || LEN2 > 256 || LEN3 < 1 || LEN3 > 256) begin : g_bad_len
    $error("rom_sequencer: LEN0..LEN3 must lie in 1..256");
  end

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [1:0] ch_q, ch_d;
  logic [3:0] en_lat_q, en_lat_d;
  logic       done_q, done_d;
  // Issue stage: remembers that an address was stepped and for which channel,
  // so the ROM word arriving next cycle can be captured.
  logic       iss_vld_q, iss_vld_d;
  logic [1:0] iss_ch_q, iss_ch_d;
  logic [7:0] dout_q, dout_d;
  logic       dvld_q, dvld_d;

  logic       step;       // address steps at the end of this cycle
  logic       step_next;  // address will step at the end of the next cycle

  // Last address of a channel.
  function automatic logic [7:0] last_addr(input logic [1:0] ch);
    logic [7:0] last;
    unique case (ch)
      2'd0:    last = 8'(LEN0 - 1);
      2'd1:    last = 8'(LEN1 - 1);
      2'd2:    last = 8'(LEN2 - 1);
      default: last = 8'(LEN3 - 1);
    endcase
    return last;
  endfunction

  // Lowest set bit of a non-zero enable mask.
  function automatic logic [1:0] lowest_set(input logic [3:0] en);
    logic [1:0] idx;
    if      (en[0]) idx = 2'd0;
    else if (en[1]) idx = 2'd1;
    else if (en[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

  // Next set bit strictly above cur, wrapping modulo 4; cur if none.
  function automatic logic [1:0] next_after(input logic [1:0] cur,
                                            input logic [3:0] en);
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    pick  = cur;
    found = 1'b0;
    for (int k = 1; k < 4; k++) begin
      idx = cur + 2'(k);
      if (!found && en[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef ROM_SEQUENCER_PACER_EN
  localparam logic [3:0] CNT_LAST = 4'(DIV - 1);

  logic [3:0] cnt_q, cnt_d;

  // Counter runs only while staying in PLAY; any entry into PLAY starts at 0.
  always_comb begin
    cnt_d = 4'd0;
    if (state_q == PLAY && state_d == PLAY) begin
      cnt_d = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  assign step      = (state_q == PLAY) && (cnt_q == CNT_LAST);
  assign step_next = (cnt_d == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end
`else
  assign step      = (state_q == PLAY);
  assign step_next = 1'b1;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ch_d      = ch_q;
    en_lat_d  = en_lat_q;
    iss_vld_d = 1'b0;
    iss_ch_d  = ch_q;
    dout_d    = dout_q;
    dvld_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.run && bus.ch_en != 4'd0) begin
          state_d  = PLAY;
          en_lat_d = bus.ch_en;
          ch_d     = lowest_set(bus.ch_en);
          addr_d   = 8'd0;
        end
      end
      PLAY: begin
        if (!bus.run) begin
          state_d = IDLE;
        end else if (step) begin
          iss_vld_d = 1'b1;
          iss_ch_d  = ch_q;
          if (addr_q == last_addr(ch_q)) begin
            // Wrap: the enable snapshot is refreshed only here, so ch_en
            // and mode changes mid-channel have no effect until now.
            addr_d   = 8'd0;
            en_lat_d = bus.ch_en;
            if (en_lat_d == 4'd0)   state_d = IDLE;
            else if (bus.mode)      ch_d = next_after(ch_q, en_lat_d);
            else if (!en_lat_d[ch_q]) ch_d = lowest_set(en_lat_d);
          end else begin
            addr_d = addr_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // ROM word for the address stepped last cycle is on rom_data now.
    if (iss_vld_q) begin
      dvld_d = 1'b1;
      unique case (iss_ch_q)
        2'd0:    dout_d = bus.rom_data0;
        2'd1:    dout_d = bus.rom_data1;
        2'd2:    dout_d = bus.rom_data2;
        default: dout_d = bus.rom_data3;
      endcase
    end

    // Leaving or staying in IDLE clears the outputs and drops in-flight
    // samples, so no data_valid ever appears outside PLAY.
    if (state_d == IDLE) begin
      addr_d    = 8'd0;
      iss_vld_d = 1'b0;
      dout_d    = 8'd0;
      dvld_d    = 1'b0;
    end

    // ch_done is registered: raise it for the cycle whose address is the
    // channel's last one and which is also a step cycle.
    done_d = (state_d == PLAY) && step_next && (addr_d == last_addr(ch_d));
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= 8'd0;
      ch_q      <= 2'd0;
      en_lat_q  <= 4'd0;
      done_q    <= 1'b0;
      iss_vld_q <= 1'b0;
      iss_ch_q  <= 2'd0;
      dout_q    <= 8'd0;
      dvld_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      ch_q      <= ch_d;
      en_lat_q  <= en_lat_d;
      done_q    <= done_d;
      iss_vld_q <= iss_vld_d;
      iss_ch_q  <= iss_ch_d;
      dout_q    <= dout_d;
      dvld_q    <= dvld_d;
    end
  end

  assign bus.rom_addr   = addr_q;
  assign bus.active_ch  = ch_q;
  assign bus.data_out   = dout_q;
  assign bus.data_valid = dvld_q;
  assign bus.ch_done    = done_q;

endmodule
